// File: rtl/aes_inv_keyschedule.sv
// AES-128 decrypt-side round-key generator: expands forward 10 rounds (1/cycle) then steps back on next.
// Load-to-valid latency 10 cycles; next yields one key per cycle; load overrides next in every state.

module sbox_element (
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] acc;
        t   = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t   = gf_mul(t, t);
            acc = gf_mul(acc, t);
        end
        return acc;
    endfunction

    logic [7:0] w_inv;

    always_comb begin
        w_inv = gf_inv(i_dat);
        o_dat = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
              ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_keyschedule (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         load,
    input  logic         next,
    output logic [127:0] round_key,
    output logic [3:0]   round,
    output logic         busy,
    output logic         key_valid
);
    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_SERVE} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_round_key;
    logic [3:0]   r_round;
    logic         r_busy;
    logic         r_key_valid;

    logic         w_do_load;
    logic         w_do_fwd;
    logic         w_do_inv;
    logic [3:0]   w_rcon_idx;
    logic [7:0]   w_rcon;
    logic [31:0]  w_a, w_b, w_c, w_d;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [127:0] w_fwd_key;
    logic [127:0] w_inv_key;

    function automatic logic [7:0] rcon_f(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (load) w_state_nxt = S_EXPAND;
            S_EXPAND: if (load) w_state_nxt = S_EXPAND;
                      else if (r_round == 4'd9) w_state_nxt = S_SERVE;
            S_SERVE:  if (load) w_state_nxt = S_EXPAND;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_do_load = load;
        w_do_fwd  = (r_state == S_EXPAND) && !load;
        w_do_inv  = (r_state == S_SERVE) && next && !load && (r_round != 4'd0);
    end

    assign {w_a, w_b, w_c, w_d} = r_round_key;

    // The four S-boxes are shared: forward feeds word 3, inverse feeds the recovered d.
    assign w_rcon_idx = (r_state == S_EXPAND) ? (r_round + 4'd1) : r_round;
    assign w_rcon     = rcon_f(w_rcon_idx);
    assign w_sub_in   = (r_state == S_EXPAND) ? w_d : (w_d ^ w_c);
    assign w_rot      = {w_sub_in[23:0], w_sub_in[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        sbox_element u_sbox (
            .i_dat (w_rot[8*g +: 8]),
            .o_dat (w_sub[8*g +: 8])
        );
    end

    always_comb begin
        logic [31:0] fa, fb, fc;
        fa        = w_a ^ w_sub ^ {w_rcon, 24'h0};
        fb        = w_b ^ fa;
        fc        = w_c ^ fb;
        w_fwd_key = {fa, fb, fc, w_d ^ fc};
        w_inv_key = {w_a ^ w_sub ^ {w_rcon, 24'h0}, w_b ^ w_a, w_c ^ w_b, w_d ^ w_c};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round_key <= '0;
            r_round     <= '0;
            r_busy      <= 1'b0;
            r_key_valid <= 1'b0;
        end else if (w_do_load) begin
            r_round_key <= key_in;
            r_round     <= '0;
            r_busy      <= 1'b1;
            r_key_valid <= 1'b0;
        end else if (w_do_fwd) begin
            r_round_key <= w_fwd_key;
            r_round     <= w_rcon_idx;
            if (w_rcon_idx == 4'd10) begin
                r_busy      <= 1'b0;
                r_key_valid <= 1'b1;
            end
        end else if (w_do_inv) begin
            r_round_key <= w_inv_key;
            r_round     <= r_round - 4'd1;
        end
    end

    assign round_key = r_round_key;
    assign round     = r_round;
    assign busy      = r_busy;
    assign key_valid = r_key_valid;
endmodule

// File: tb/tb_aes_inv_keyschedule.sv
// Directed and random-key bench for aes_inv_keyschedule against a table-driven forward key-expansion model.
module tb_aes_inv_keyschedule;
    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         next;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   round;
    logic         busy;
    logic         key_valid;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    logic [127:0] exp_keys [0:10];

    aes_inv_keyschedule dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .load      (load),
        .next      (next),
        .round_key (round_key),
        .round     (round),
        .busy      (busy),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        return SBOX[2047 - 8*x -: 8];
    endfunction

    function automatic logic [7:0] rcon_m(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        return v;
    endfunction

    function automatic logic [127:0] fwd_step(input logic [127:0] k, input int r);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
        w0 = w0 ^ t ^ {rcon_m(r), 24'h0};
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    task automatic expand_model(input logic [127:0] k);
        exp_keys[0] = k;
        for (int r = 1; r <= 10; r++) exp_keys[r] = fwd_step(exp_keys[r-1], r);
    endtask

    initial begin
        logic [127:0] k;
        int busy_cnt;

        rst = 1'b1; load = 1'b1; next = 1'b0; key_in = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        tick; tick;
        check("rst_key", round_key, 128'h0);
        check("rst_round", {124'h0, round}, 128'h0);
        check("rst_busy", {127'h0, busy}, 128'h0);
        check("rst_kv", {127'h0, key_valid}, 128'h0);
        rst = 1'b0; load = 1'b0;

        // FIPS-197 forward expansion, with next held high (must be ignored)
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        expand_model(k);
        key_in = k; load = 1'b1; tick; load = 1'b0;
        check("load_busy", {127'h0, busy}, 128'h1);
        check("load_round", {124'h0, round}, 128'h0);
        check("load_key", round_key, k);
        check("load_kv", {127'h0, key_valid}, 128'h0);
        busy_cnt = busy ? 1 : 0;
        next = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (busy) busy_cnt++;
            check("exp_round", {124'h0, round}, 128'(i));
            check("exp_key", round_key, exp_keys[i]);
            if (i == 1) check("fips_rk1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        end
        check("busy_cycles", 128'(busy_cnt), 128'd10);
        check("e10_busy", {127'h0, busy}, 128'h0);
        check("e10_kv", {127'h0, key_valid}, 128'h1);
        check("fips_rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reverse walk: next stays high for back-to-back pulses
        for (int i = 9; i >= 0; i--) begin
            tick;
            check("rev_round", {124'h0, round}, 128'(i));
            check("rev_key", round_key, exp_keys[i]);
            check("rev_kv", {127'h0, key_valid}, 128'h1);
            if (i == 9) check("fips_rk9", round_key, 128'hac7766f319fadc2128d12941575c006e);
            if (i == 0) check("fips_rk0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        end
        tick;
        check("hold0_round", {124'h0, round}, 128'h0);
        check("hold0_key", round_key, k);
        check("hold0_kv", {127'h0, key_valid}, 128'h1);
        next = 1'b0;

        // load+next together in SERVE at round 5
        key_in = 128'h000102030405060708090a0b0c0d0e0f; load = 1'b1; tick; load = 1'b0;
        repeat (10) tick;
        next = 1'b1;
        repeat (5) tick;
        next = 1'b0;
        check("serve_r5", {124'h0, round}, 128'd5);
        key_in = 128'hffeeddccbbaa99887766554433221100;
        load = 1'b1; next = 1'b1; tick; load = 1'b0; next = 1'b0;
        check("ln_round", {124'h0, round}, 128'h0);
        check("ln_busy", {127'h0, busy}, 128'h1);
        check("ln_kv", {127'h0, key_valid}, 128'h0);
        check("ln_key", round_key, 128'hffeeddccbbaa99887766554433221100);

        // Restart mid-EXPAND with the all-zero key
        repeat (4) tick;
        check("mid_r4", {124'h0, round}, 128'd4);
        key_in = 128'h0; load = 1'b1; tick; load = 1'b0;
        check("restart_r0", {124'h0, round}, 128'h0);
        repeat (10) tick;
        check("zero_rk10", round_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero_round", {124'h0, round}, 128'd10);
        check("zero_kv", {127'h0, key_valid}, 128'h1);

        // Reset at round 6, with a simultaneous load that must be dropped
        key_in = 128'h0f0e0d0c0b0a09080706050403020100; load = 1'b1; tick; load = 1'b0;
        repeat (6) tick;
        check("pre_rst_r6", {124'h0, round}, 128'd6);
        rst = 1'b1; load = 1'b1; tick; rst = 1'b0; load = 1'b0;
        check("mrst_key", round_key, 128'h0);
        check("mrst_round", {124'h0, round}, 128'h0);
        check("mrst_busy", {127'h0, busy}, 128'h0);
        check("mrst_kv", {127'h0, key_valid}, 128'h0);
        tick;
        check("mrst_idle_busy", {127'h0, busy}, 128'h0);
        check("mrst_idle_key", round_key, 128'h0);

        // Random keys: forward chain against the model, then back to key_in
        for (int n = 0; n < 200; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand_model(k);
            key_in = k; load = 1'b1; tick; load = 1'b0;
            for (int r = 1; r <= 10; r++) begin
                tick;
                check("rand_fwd", round_key, exp_keys[r]);
            end
            next = 1'b1;
            for (int r = 9; r >= 0; r--) begin
                tick;
                check("rand_rev", round_key, exp_keys[r]);
            end
            next = 1'b0;
            check("rand_back", round_key, k);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
